// File: rtl/bcd7_pkg.sv
// Shared segment encodings and polarity helper for the BCD 7-segment scan driver.
// Segment vectors are {a,b,c,d,e,f,g}, active-high (1 = lit).
package bcd7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Converts an active-high segment vector to the board's pin polarity.
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg_hi, input logic active_low);
        logic [6:0] seg_pin;
        if (active_low) begin
            seg_pin = ~seg_hi;
        end else begin
            seg_pin = seg_hi;
        end
        return seg_pin;
    endfunction

endpackage

// File: rtl/bcd_7seg_decode.sv
// Combinational BCD nibble to active-high 7-segment decoder.
// Codes 10..15 render as a dash and raise the invalid flag.
module bcd_7seg_decode
    import bcd7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg,
    output logic       invalid
);

    // Nibble lookup; anything outside 0..9 is shown as a dash.
    always_comb begin
        seg     = SEG_DASH;
        invalid = 1'b0;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: begin
                seg     = SEG_DASH;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed N-digit BCD display driver: double-buffered word, one digit per
// refresh slot, leading-zero suppression, blanking and selectable pin polarity.
module bcd_7seg_scan_driver
    import bcd7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    err
);

    localparam int PW = (REFRESH_DIV > 32'sd1) ? $clog2(REFRESH_DIV) : 32'sd1;
    localparam int IW = (NUM_DIGITS > 32'sd1) ? $clog2(NUM_DIGITS) : 32'sd1;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 32'sd1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 32'sd1);
    localparam logic                  SEG_INV    = (SEG_ACTIVE_LOW != 32'sd0);
    localparam logic                  AN_INV     = (AN_ACTIVE_LOW != 32'sd0);
    localparam logic                  LZ_EN      = (LZ_SUPPRESS != 32'sd0);
    localparam logic [NUM_DIGITS-1:0] AN_MASK    = AN_INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_IDLE   = seg_polarity(SEG_OFF, SEG_INV);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;
    logic                    err_q, err_d;

    logic                    tick_s;
    logic                    wrap_s;
    logic [6:0]              dec_seg_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   dec_inv_s;
    logic [NUM_DIGITS-1:0]   dark_s;
    logic                    zero_above_s;
    logic [6:0]              seg_hi_s;
    logic                    dp_hi_s;
    logic [NUM_DIGITS-1:0]   an_hi_s;

    // One decoder per displayed nibble so err can see every digit at once.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
        bcd_7seg_decode u_dec (
            .nibble  (disp_bcd_q[4*gi +: 4]),
            .seg     (dec_seg_s[gi]),
            .invalid (dec_inv_s[gi])
        );
    end

    // Refresh prescaler and digit index; the index wrap marks the frame boundary.
    always_comb begin
        tick_s = (presc_q == PRESC_LAST);
        wrap_s = tick_s && (idx_q == IDX_LAST);
        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (wrap_s) begin
            idx_d = {IW{1'b0}};
        end else if (tick_s) begin
            idx_d = idx_q + IW'(1);
        end else begin
            idx_d = idx_q;
        end
        fd_d = wrap_s;
    end

    // Pending buffer takes every load; display buffer only changes at the wrap,
    // so a digit never tears mid-frame and a load on the wrap cycle waits a frame.
    always_comb begin
        if (load) begin
            pend_bcd_d = bcd_in;
            pend_dp_d  = dp_in;
        end else begin
            pend_bcd_d = pend_bcd_q;
            pend_dp_d  = pend_dp_q;
        end
        if (wrap_s) begin
            disp_bcd_d = pend_bcd_q;
            disp_dp_d  = pend_dp_q;
        end else begin
            disp_bcd_d = disp_bcd_q;
            disp_dp_d  = disp_dp_q;
        end
    end

    // Leading-zero map: a digit goes dark when it and everything above it is zero.
    always_comb begin
        zero_above_s = 1'b1;
        dark_s       = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 32'sd1; i > 32'sd0; i--) begin
            zero_above_s = zero_above_s & (disp_bcd_q[4*i +: 4] == 4'd0);
            dark_s[i]    = zero_above_s & LZ_EN;
        end
    end

    // Output selection; polarity is applied last so blanking stays polarity-agnostic.
    always_comb begin
        seg_hi_s = SEG_OFF;
        dp_hi_s  = 1'b0;
        an_hi_s  = {NUM_DIGITS{1'b0}};
        if (blank) begin
            seg_hi_s = SEG_OFF;
            dp_hi_s  = 1'b0;
            an_hi_s  = {NUM_DIGITS{1'b0}};
        end else begin
            if (dark_s[idx_q]) begin
                seg_hi_s = SEG_OFF;
            end else begin
                seg_hi_s = dec_seg_s[idx_q];
            end
            dp_hi_s = disp_dp_q[idx_q];
            an_hi_s = AN_ONE << idx_q;
        end
        seg_d = seg_polarity(seg_hi_s, SEG_INV);
        dp_d  = dp_hi_s ^ SEG_INV;
        an_d  = an_hi_s ^ AN_MASK;
        err_d = |dec_inv_s;
    end

    // State and output registers; reset drives every pin to its unlit/deselected level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= {PW{1'b0}};
            idx_q      <= {IW{1'b0}};
            pend_bcd_q <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_q  <= {NUM_DIGITS{1'b0}};
            disp_bcd_q <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_q  <= {NUM_DIGITS{1'b0}};
            seg_q      <= SEG_IDLE;
            dp_q       <= SEG_INV;
            an_q       <= AN_MASK;
            fd_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_bcd_q <= pend_bcd_d;
            pend_dp_q  <= pend_dp_d;
            disp_bcd_q <= disp_bcd_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
            err_q      <= err_d;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule
